mem_lsu_queue: RTL and testbench
================================

// Module: mem_lsu_queue
// PURPOSE
//  MEM-stage load/store unit with a parametrised in-order outstanding-request queue. Replaces
//  the single-outstanding MEM handshake: issues up to DEPTH pipelined data-cache requests,
//  matches in-order data_ok returns, aligns and extends load data, and hands results to WB.
//  Sits between the EX/MEM latch and the MEM/WB latch; flushed by the exception/refetch flush.
// PARAMETERS
//  DATA_W  32  data width (lanes = DATA_W/8; size encodings beyond LOG2(DATA_W/8) illegal)
//  ADDR_W  32  physical address width
//  DEPTH   4   max outstanding requests (power of 2, >=2)
//  RD_W    5   destination register address width
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous reset, active-high
//  in_valid_i   in   1         EX/MEM holds a valid, exception-free memory op
//  in_ready_o   out  1         op accepted this cycle (req_o & addr_ok_i)
//  in_we_i      in   1         1 = store, 0 = load
//  in_size_i    in   2         0 byte, 1 half, 2 word
//  in_sext_i    in   1         load sign-extend (ignored for word / store)
//  in_addr_i    in   ADDR_W    physical address
//  in_wdata_i   in   DATA_W    store data, LSB-aligned
//  in_rd_i      in   RD_W      load destination register
//  req_o        out  1         data-cache request
//  we_o         out  1         request is write
//  addr_o       out  ADDR_W    = in_addr_i
//  wstrb_o      out  DATA_W/8  byte enables
//  wdata_o      out  DATA_W    lane-replicated store data
//  addr_ok_i    in   1         cache accepted request
//  data_ok_i    in   1         oldest in-flight request completed
//  rdata_i      in   DATA_W    raw read data, valid with data_ok_i
//  out_valid_o  out  1         head result ready for WB
//  out_ready_i  in   1         WB allowin
//  out_we_o     out  1         head was store (no regfile write)
//  out_rd_o     out  RD_W      head destination register
//  out_rdata_o  out  DATA_W    aligned/extended load data (0 for store)
//  flush_i      in   1         exception/refetch flush
//  busy_o       out  1         any entry not FREE (incl. discards)
// BEHAVIOUR
//  - Entry state: FREE, WAIT (in flight), DONE; plus discard bit. Pointers alloc/data/retire
//    wrap mod DEPTH; cnt 0..DEPTH counts non-FREE entries.
//  - req_o = in_valid_i & (cnt<DEPTH) & ~flush_i; we_o = in_we_i. Push at edge when req_o &
//    addr_ok_i: entry[alloc]<=WAIT with we/size/sext/addr[1:0]/rd, alloc++.
//  - wstrb: byte 1<<a[1:0]; half 3<<(2*a[1]); word all ones. wdata: byte x4, half x2, word as is.
//  - data_ok_i: entry[data] WAIT->DONE (or ->FREE if discard), data++. Lane select by stored
//    a[1:0], zero/sign extend per size/sext, result registered: out_valid_o earliest 1 cycle
//    after data_ok_i. data_ok_i with no WAIT entry is a protocol error (assertion).
//  - out_valid_o = entry[retire]==DONE & ~flush_i. Pop when out_valid_o & out_ready_i;
//    retire++. Stalled head holds outputs stable.
//  - Push, data_ok, pop in same cycle all legal; cnt updates by +push -free; full with
//    simultaneous pop does NOT accept (req_o uses registered cnt).
//  - flush_i: no push, no pop this cycle; at edge all DONE -> FREE, all WAIT set discard,
//    retire advances past freed/discard entries (retire<=data). A data_ok_i in the flush
//    cycle frees its entry directly. Discards free silently on later data_ok_i.
//  - Reset: all entries FREE, pointers/cnt 0; outputs req_o, in_ready_o, out_valid_o,
//    busy_o = 0; out_* data = 0. Reset mid-operation abandons in-flight data_ok (cache reset too).
// TESTING
//  - Single lb from 0x1003, rdata 0x80xxxxxx -> out_rdata 0xFFFFFF80, out_valid 1 cycle after data_ok.
//  - 4 back-to-back lw, addr_ok always 1, data_ok delayed 3 cycles -> req_o drops at cnt=4, results in order.
//  - sh to 0x2002 data 0x1234 -> wstrb 4'b1100, wdata 0x12341234, out_we 1, out_rdata 0.
//  - Flush with 2 WAIT + 1 DONE -> out_valid 0, next 2 data_ok discarded, busy_o 0 after, new req ok.
//  - out_ready_i low 5 cycles while 3 data_ok arrive -> head stable, queue fills, no data lost.
//  - rst asserted with 3 outstanding -> next cycle cnt 0, req_o/out_valid_o/busy_o 0.

Source files
------------

// File: rtl/mem_lsu_queue.sv
// MEM-stage load/store unit with an in-order queue of outstanding data-cache requests.
// Requests are issued back-to-back up to DEPTH deep; in-order data_ok returns are aligned,
// extended and parked in the entry until WB takes them from the head.
module mem_lsu_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RD_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_we_i,
  input  logic [1:0]            in_size_i,
  input  logic                  in_sext_i,
  input  logic [ADDR_W-1:0]     in_addr_i,
  input  logic [DATA_W-1:0]     in_wdata_i,
  input  logic [RD_W-1:0]       in_rd_i,
  output logic                  req_o,
  output logic                  we_o,
  output logic [ADDR_W-1:0]     addr_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic [DATA_W-1:0]     wdata_o,
  input  logic                  addr_ok_i,
  input  logic                  data_ok_i,
  input  logic [DATA_W-1:0]     rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_we_o,
  output logic [RD_W-1:0]       out_rd_o,
  output logic [DATA_W-1:0]     out_rdata_o,
  input  logic                  flush_i,
  output logic                  busy_o
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } ent_state_e;

  // Per-entry bookkeeping
  ent_state_e          st_q   [DEPTH];
  ent_state_e          st_d   [DEPTH];
  logic                dis_q  [DEPTH];
  logic                dis_d  [DEPTH];
  logic                ewe_q  [DEPTH];
  logic                ewe_d  [DEPTH];
  logic [1:0]          esz_q  [DEPTH];
  logic [1:0]          esz_d  [DEPTH];
  logic                esx_q  [DEPTH];
  logic                esx_d  [DEPTH];
  logic [OFF_W-1:0]    eoff_q [DEPTH];
  logic [OFF_W-1:0]    eoff_d [DEPTH];
  logic [RD_W-1:0]     erd_q  [DEPTH];
  logic [RD_W-1:0]     erd_d  [DEPTH];
  logic [DATA_W-1:0]   eres_q [DEPTH];
  logic [DATA_W-1:0]   eres_d [DEPTH];

  logic [PTR_W-1:0]    alloc_q, alloc_d;
  logic [PTR_W-1:0]    dptr_q,  dptr_d;
  logic [PTR_W-1:0]    ret_q,   ret_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;

  logic                push_c;
  logic                pop_c;
  logic [OFF_W-1:0]    in_off_c;

  // Select the addressed lanes of raw read data and zero/sign extend them.
  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] raw,
                                                 input logic [1:0]        sz,
                                                 input logic              sx,
                                                 input logic [OFF_W-1:0]  off);
    int                nb;
    logic [OFF_W-1:0]  base;
    logic [DATA_W-1:0] sh;
    logic              sgn;
    logic [DATA_W-1:0] r;
    nb   = int'(32'd1 << sz);
    base = off & ~OFF_W'(nb - 1);
    sh   = raw >> {base, 3'b000};
    sgn  = 1'b0;
    r    = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (l == nb - 1) sgn = sh[8*l+7];
    end
    for (int l = 0; l < int'(LANES); l++) begin
      if (l < nb) r[8*l +: 8] = sh[8*l +: 8];
      else        r[8*l +: 8] = {8{sx & sgn}};
    end
    return r;
  endfunction

  // Request side handshake: registered occupancy gates issue, so a pop never frees a slot early
  always_comb begin
    req_o      = in_valid_i & (cnt_q < CNT_W'(DEPTH)) & ~flush_i;
    in_ready_o = req_o & addr_ok_i;
    push_c     = in_ready_o;
    we_o       = in_we_i;
    addr_o     = in_addr_i;
    in_off_c   = in_addr_i[OFF_W-1:0];
  end

  // Byte enables and lane-replicated store data
  always_comb begin : store_fmt
    int               nb;
    logic [OFF_W-1:0] base;
    nb      = int'(32'd1 << in_size_i);
    base    = in_off_c & ~OFF_W'(nb - 1);
    wstrb_o = '0;
    wdata_o = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      wstrb_o[l] = (l >= int'(base)) && (l < int'(base) + nb);
      for (int k = 0; k < int'(LANES); k++) begin
        if (k == (l % nb)) wdata_o[8*l +: 8] = in_wdata_i[8*k +: 8];
      end
    end
  end

  // Head of queue presented to WB; a stalled head keeps every field stable
  always_comb begin
    out_valid_o = (st_q[ret_q] == ST_DONE) & ~flush_i;
    pop_c       = out_valid_o & out_ready_i;
    out_we_o    = ewe_q[ret_q];
    out_rd_o    = erd_q[ret_q];
    out_rdata_o = eres_q[ret_q];
    busy_o      = (cnt_q != '0);
  end

  // Next-state: push, in-order completion, retire and flush
  always_comb begin
    st_d    = st_q;
    dis_d   = dis_q;
    ewe_d   = ewe_q;
    esz_d   = esz_q;
    esx_d   = esx_q;
    eoff_d  = eoff_q;
    erd_d   = erd_q;
    eres_d  = eres_q;
    alloc_d = alloc_q;
    dptr_d  = dptr_q;
    ret_d   = ret_q;
    cnt_d   = '0;

    if (push_c) begin
      st_d[alloc_q]   = ST_WAIT;
      dis_d[alloc_q]  = 1'b0;
      ewe_d[alloc_q]  = in_we_i;
      esz_d[alloc_q]  = in_size_i;
      esx_d[alloc_q]  = in_sext_i;
      eoff_d[alloc_q] = in_off_c;
      erd_d[alloc_q]  = in_rd_i;
      alloc_d         = alloc_q + PTR_W'(1);
    end

    if (data_ok_i && st_q[dptr_q] == ST_WAIT) begin
      if (dis_q[dptr_q] || flush_i) begin
        st_d[dptr_q]  = ST_FREE;
        dis_d[dptr_q] = 1'b0;
        // Discards sit at the retire pointer; step it past the freed slot
        if (dis_q[dptr_q]) ret_d = ret_q + PTR_W'(1);
      end else begin
        st_d[dptr_q]   = ST_DONE;
        eres_d[dptr_q] = ewe_q[dptr_q] ? '0
                       : fmt_load(rdata_i, esz_q[dptr_q], esx_q[dptr_q], eoff_q[dptr_q]);
      end
      dptr_d = dptr_q + PTR_W'(1);
    end

    if (pop_c) begin
      st_d[ret_q] = ST_FREE;
      ret_d       = ret_q + PTR_W'(1);
    end

    if (flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (st_d[i] == ST_DONE) st_d[i] = ST_FREE;
        if (st_d[i] == ST_WAIT) dis_d[i] = 1'b1;
      end
      ret_d = dptr_d;
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (st_d[i] != ST_FREE) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        st_q[i]   <= ST_FREE;
        dis_q[i]  <= 1'b0;
        ewe_q[i]  <= 1'b0;
        esz_q[i]  <= '0;
        esx_q[i]  <= 1'b0;
        eoff_q[i] <= '0;
        erd_q[i]  <= '0;
        eres_q[i] <= '0;
      end
      alloc_q <= '0;
      dptr_q  <= '0;
      ret_q   <= '0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      dis_q   <= dis_d;
      ewe_q   <= ewe_d;
      esz_q   <= esz_d;
      esx_q   <= esx_d;
      eoff_q  <= eoff_d;
      erd_q   <= erd_d;
      eres_q  <= eres_d;
      alloc_q <= alloc_d;
      dptr_q  <= dptr_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // A completion must always have a request in flight
  always_ff @(posedge clk) begin
    if (!rst && data_ok_i) begin
      assert (st_q[dptr_q] == ST_WAIT)
        else $error("mem_lsu_queue: data_ok_i with no request in flight");
    end
  end

endmodule

// File: tb/tb_mem_lsu_queue.sv
// Directed bench for mem_lsu_queue: stimulus pushes expected WB results into a scoreboard,
// an independent monitor pops and compares on every WB handshake.
module tb_mem_lsu_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o, in_we_i, in_sext_i;
  logic [1:0]  in_size_i;
  logic [31:0] in_addr_i, in_wdata_i;
  logic [4:0]  in_rd_i;
  logic        req_o, we_o;
  logic [31:0] addr_o, wdata_o;
  logic [3:0]  wstrb_o;
  logic        addr_ok_i, data_ok_i;
  logic [31:0] rdata_i;
  logic        out_valid_o, out_ready_i, out_we_o;
  logic [4:0]  out_rd_o;
  logic [31:0] out_rdata_o;
  logic        flush_i, busy_o;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  mem_lsu_queue dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_we_i(in_we_i),
    .in_size_i(in_size_i), .in_sext_i(in_sext_i), .in_addr_i(in_addr_i),
    .in_wdata_i(in_wdata_i), .in_rd_i(in_rd_i),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wstrb_o(wstrb_o), .wdata_o(wdata_o),
    .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .rdata_i(rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_we_o(out_we_o),
    .out_rd_o(out_rd_o), .out_rdata_o(out_rdata_o),
    .flush_i(flush_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every WB handshake must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got rd %0d data 0x%08h, expected no result", out_rd_o, out_rdata_o);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_we",    32'(out_we_o),    32'(mon_e.we));
        chk("sb_rd",    32'(out_rd_o),    32'(mon_e.rd));
        chk("sb_rdata", out_rdata_o,      mon_e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op and hold it until accepted (bounded)
  task automatic issue(input logic we, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] expd,
                       input bit track);
    int n;
    in_valid_i = 1'b1; in_we_i = we; in_size_i = sz; in_sext_i = sx;
    in_addr_i = a; in_wdata_i = wd; in_rd_i = rd;
    n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("issue_accept", 32'(in_ready_o), 32'd1);
    if (track && in_ready_o) sb.push_back({we, rd, expd});
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic dok(input logic [31:0] d);
    data_ok_i = 1'b1;
    rdata_i   = d;
    step();
    data_ok_i = 1'b0;
    rdata_i   = '0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk(nm, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lw_dat [4];
    lw_dat[0] = 32'h11112222; lw_dat[1] = 32'h33334444;
    lw_dat[2] = 32'hCAFEF00D; lw_dat[3] = 32'h0BADBEEF;

    rst = 1'b1; in_valid_i = 0; in_we_i = 0; in_size_i = 0; in_sext_i = 0;
    in_addr_i = 0; in_wdata_i = 0; in_rd_i = 0; addr_ok_i = 1'b1; data_ok_i = 0;
    rdata_i = 0; out_ready_i = 1'b1; flush_i = 0;
    step(); step();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_busy",      32'(busy_o),      32'd0);
    chk("rst_req",       32'(req_o),       32'd0);
    chk("rst_in_ready",  32'(in_ready_o),  32'd0);
    chk("rst_rdata",     out_rdata_o,      32'd0);
    step();
    rst = 1'b0;

    // lb sign-extended from lane 3, one-cycle result latency
    issue(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd5, 32'hFFFFFF80, 1'b1);
    data_ok_i = 1'b1; rdata_i = 32'h80123456;
    @(negedge clk);
    chk("lb_valid_early", 32'(out_valid_o), 32'd0);
    step();
    data_ok_i = 1'b0;
    @(negedge clk);
    chk("lb_valid_late", 32'(out_valid_o), 32'd1);
    chk("lb_rdata",      out_rdata_o,      32'hFFFFFF80);
    drain("lb_drain");

    // Four back-to-back lw fill the queue; fifth request is held off
    for (int i = 0; i < 4; i++)
      issue(1'b0, 2'd2, 1'b0, 32'h100 + 32'(4*i), 32'h0, 5'(10 + i), lw_dat[i], 1'b1);
    in_valid_i = 1'b1; in_addr_i = 32'h110;
    @(negedge clk);
    chk("full_req",      32'(req_o),      32'd0);
    chk("full_in_ready", 32'(in_ready_o), 32'd0);
    chk("full_busy",     32'(busy_o),     32'd1);
    step();
    in_valid_i = 1'b0;
    step(); step();
    for (int i = 0; i < 4; i++) dok(lw_dat[i]);
    drain("lw_drain");

    // Stores: byte enables, replication, zero result
    in_valid_i = 1'b1; in_we_i = 1'b1; in_size_i = 2'd1; in_sext_i = 1'b0;
    in_addr_i = 32'h2002; in_wdata_i = 32'h00001234; in_rd_i = 5'd7;
    @(negedge clk);
    chk("sh_req",   32'(req_o),   32'd1);
    chk("sh_we",    32'(we_o),    32'd1);
    chk("sh_addr",  addr_o,       32'h2002);
    chk("sh_wstrb", 32'(wstrb_o), 32'hC);
    chk("sh_wdata", wdata_o,      32'h12341234);
    sb.push_back({1'b1, 5'd7, 32'h0});
    step();
    in_valid_i = 1'b0;
    dok(32'hDEADBEEF);
    in_valid_i = 1'b1; in_size_i = 2'd0; in_addr_i = 32'h3001; in_wdata_i = 32'hFFFFFFAB; in_rd_i = 5'd0;
    @(negedge clk);
    chk("sb_wstrb", 32'(wstrb_o), 32'h2);
    chk("sb_wdata", wdata_o,      32'hABABABAB);
    sb.push_back({1'b1, 5'd0, 32'h0});
    step();
    in_valid_i = 1'b0;
    dok(32'h0);
    drain("st_drain");

    // Assorted load alignments
    issue(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 5'd3, 32'hFFFF8001, 1'b1);
    dok(32'h80011234);
    issue(1'b0, 2'd1, 1'b0, 32'h2000, 32'h0, 5'd4, 32'h00009876, 1'b1);
    dok(32'hABCD9876);
    issue(1'b0, 2'd0, 1'b0, 32'h1001, 32'h0, 5'd6, 32'h000000A5, 1'b1);
    dok(32'h0000A500);
    drain("ld_drain");

    // Flush with one DONE and two WAIT entries
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(1'b0, 2'd2, 1'b0, 32'h400 + 32'(4*i), 32'h0, 5'(1 + i), 32'h0, 1'b0);
    dok(32'h55555555);
    @(negedge clk);
    chk("fl_pre_valid", 32'(out_valid_o), 32'd1);
    step();
    flush_i = 1'b1;
    @(negedge clk);
    chk("fl_valid_in_flush", 32'(out_valid_o), 32'd0);
    step();
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("fl_post_valid", 32'(out_valid_o), 32'd0);
    chk("fl_post_busy",  32'(busy_o),      32'd1);
    step();
    dok(32'h66666666);
    dok(32'h77777777);
    @(negedge clk);
    chk("fl_discard_valid", 32'(out_valid_o), 32'd0);
    chk("fl_idle_busy",     32'(busy_o),      32'd0);
    step();
    issue(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 5'd9, 32'h12345678, 1'b1);
    dok(32'h12345678);
    drain("fl_drain");

    // WB stall while results arrive; head stays put and queue fills
    out_ready_i = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h600, 32'h0, 5'd20, 32'hA0A0A0A0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h601, 32'h0, 5'd21, 32'h0000007F, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h602, 32'h0, 5'd22, 32'h0000BEEF, 1'b1);
    dok(32'hA0A0A0A0);
    dok(32'h00007F00);
    dok(32'hBEEF0000);
    @(negedge clk);
    chk("stall_valid", 32'(out_valid_o), 32'd1);
    chk("stall_rd",    32'(out_rd_o),    32'd20);
    chk("stall_rdata", out_rdata_o,      32'hA0A0A0A0);
    step(); step();
    @(negedge clk);
    chk("stall_rd_hold",    32'(out_rd_o), 32'd20);
    chk("stall_rdata_hold", out_rdata_o,   32'hA0A0A0A0);
    step();
    issue(1'b0, 2'd2, 1'b0, 32'h604, 32'h0, 5'd23, 32'h0F0F0F0F, 1'b1);
    in_valid_i = 1'b1;
    @(negedge clk);
    chk("stall_full_req", 32'(req_o), 32'd0);
    step();
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    dok(32'h0F0F0F0F);
    drain("stall_drain");

    // Reset with three requests outstanding
    for (int i = 0; i < 3; i++)
      issue(1'b0, 2'd2, 1'b0, 32'h700 + 32'(4*i), 32'h0, 5'(24 + i), 32'h0, 1'b0);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst_busy",  32'(busy_o),      32'd0);
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_req",   32'(req_o),       32'd0);
    chk("mid_rst_rdata", out_rdata_o,      32'd0);
    step();
    rst = 1'b0;
    issue(1'b0, 2'd1, 1'b1, 32'h802, 32'h0, 5'd30, 32'h00007001, 1'b1);
    dok(32'h70010000);
    drain("rst_drain");

    step(); step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
